bf_ifetch: RTL and testbench
============================

Name: bf_ifetch

Overview:
- Instruction-fetch initiator for the bfcpu core.
- Drives the i_req/i_addr/i_ack/i_rdata port of the instruction memory.
- Prefetches sequential bytes into a small FIFO and presents them to the decoder over a valid/ready handshake.
- Handles PC redirects from loop jumps ('[' / ']') by aborting any outstanding fetch and flushing the FIFO.

Parameters:
- i_addr_width, 8'd16, width of the instruction address and the PC.
- i_mem_length, 32'd1024, number of program bytes; fetching stops at PC == i_mem_length.
- fifo_depth, 4, number of prefetch entries; must be a power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_req  output  1  fetch request to the instruction memory.
- i_addr  output  i_addr_width  fetch address; held stable while i_req=1.
- i_ack  input  1  memory acknowledge; when high, i_rdata is valid that cycle.
- i_rdata  input  8  fetched instruction byte.
- redirect  input  1  one-cycle pulse that loads a new PC.
- redirect_addr  input  i_addr_width  jump target.
- inst_valid  output  1  FIFO head holds a valid instruction.
- inst_ready  input  1  decoder accepts the head this cycle.
- inst_data  output  8  instruction byte at the FIFO head.
- inst_addr  output  i_addr_width  address of the instruction at the FIFO head.
- fetch_done  output  1  PC has reached i_mem_length and no fetch is outstanding.

Behaviour:
- Reset (async, rst_n=0):
  - PC=0, FIFO empty, state=GAP.
  - i_req=0, i_addr=0, inst_valid=0, inst_data=0, inst_addr=0, fetch_done=0.
- Memory protocol rules; the memory acks one cycle after i_req rises and keeps acking while i_req stays high:
  - i_req and i_addr are registered outputs. i_addr changes only when i_req=0 or in the cycle i_req rises.
  - i_req stays high until the cycle i_ack=1 is seen, then drops on the next edge.
  - After each ack, and after each abort, i_req is held low for at least one full cycle (GAP) before the next rise. This prevents a stale ack.
  - Minimum fetch period: 3 cycles (REQ, REQ+ACK, GAP).
- States:
  - GAP: i_req=0. Next state:
    - DONE if PC == i_mem_length.
    - REQ if the FIFO has a free slot, counting the slot freed by a same-cycle pop.
    - Otherwise stay in GAP.
  - REQ: i_req=1, i_addr=PC.
    - On i_ack: write {i_rdata, PC} into the FIFO, PC<=PC+1, go to GAP.
  - DONE: i_req=0, fetch_done=1 once the FIFO is irrelevant (fetch_done does not wait for the FIFO to drain). Leave only on redirect.
- Redirect, highest priority, any state:
  - FIFO flushed; inst_valid=0 on the next cycle.
  - PC<=redirect_addr, i_req<=0, state<=GAP.
  - Any i_ack in the redirect cycle is discarded: no FIFO write, no PC increment.
  - An inst_ready pop in the same cycle is a no-op, since the flush wins.
  - fetch_done clears.
- FIFO:
  - Push on ack, pop on inst_valid & inst_ready.
  - Simultaneous push and pop when full is legal; occupancy is unchanged.
  - Pointers wrap modulo fifo_depth.
  - inst_data and inst_addr reflect the head combinationally from registered storage.
  - Data is undefined when inst_valid=0; the bench must not check it.
- Arithmetic:
  - PC increment is i_addr_width-bit modulo.
  - The end check compares the zero-extended PC against i_mem_length.
  - A redirect_addr >= i_mem_length goes straight to DONE via GAP.
- Back-pressure: with inst_ready=0, fetching stalls with i_req=0 once the FIFO is full. No request is issued without a guaranteed free slot.

Test Plan:
- Reset release, memory preloaded with 0x2B,0x3E,0x5B,0x2D at 0..3, inst_ready=1 -> i_req first rises 1 cycle after reset; i_addr sequence 0,1,2,3; i_req low at least one cycle between each ack; decoder receives 0x2B@0, 0x3E@1, 0x5B@2, 0x2D@3 in order.
- inst_ready held 0 with fifo_depth=4 -> exactly 4 acks, then i_req stays 0 and inst_data stays 0x2B@0. Raise inst_ready for 1 cycle -> exactly one new fetch, at address 4.
- Redirect to 0x0010 in the same cycle as i_ack for address 2 -> byte 2 is never delivered; next i_addr=0x0010 after a GAP cycle; first post-redirect inst_addr=0x0010.
- Redirect while in REQ before the ack -> i_req drops next cycle and stays low at least one cycle; no spurious FIFO entry; subsequent fetch reads redirect_addr.
- i_mem_length=8, run to the end -> fetch_done=1 after the ack for address 7; no i_req afterwards. Redirect to 3 -> fetch_done=0 and fetching resumes at 3.
- Assert rst_n=0 mid-REQ with the FIFO holding 2 entries -> i_req=0 and inst_valid=0 immediately (asynchronously); after release, fetching restarts at address 0.

Source files
------------

// File: rtl/bf_ifetch.sv
// bf_ifetch -- instruction-fetch initiator for the bfcpu core.
//
// Fetches program bytes one at a time from the instruction memory and queues
// them in a small prefetch FIFO. The decoder reads the FIFO over a
// valid/ready handshake. A redirect aborts any outstanding fetch, flushes the
// FIFO and restarts fetching at the jump target.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req, i_addr              fetch request / address (registered)
//   i_ack, i_rdata             memory acknowledge and returned byte
//   redirect, redirect_addr    one-cycle PC load (loop jump)
//   inst_valid, inst_ready     decoder handshake on the FIFO head
//   inst_data, inst_addr       byte and address at the FIFO head
//   fetch_done                 PC is at/after the program end, nothing in flight
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_GAP  | i_req low; masks a stale ack, then decides REQ / DONE / wait
// ST_REQ  | i_req high at i_addr=PC, waiting for i_ack
// ST_DONE | PC reached program end; idle until a redirect
module bf_ifetch #(
  parameter int unsigned i_addr_width = 16,
  parameter logic [31:0] i_mem_length = 32'd1024,
  parameter int unsigned fifo_depth   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    i_req,
  output logic [i_addr_width-1:0] i_addr,
  input  logic                    i_ack,
  input  logic [7:0]              i_rdata,
  input  logic                    redirect,
  input  logic [i_addr_width-1:0] redirect_addr,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [7:0]              inst_data,
  output logic [i_addr_width-1:0] inst_addr,
  output logic                    fetch_done
);

  localparam int unsigned PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CMP_W = (i_addr_width > 32) ? i_addr_width : 32;

  localparam logic [CNT_W-1:0]        FIFO_FULL = CNT_W'(fifo_depth);
  localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]        PTR_ONE   = PTR_W'(1);
  localparam logic [i_addr_width-1:0] PC_ONE    = i_addr_width'(1);
  localparam logic [CMP_W-1:0]        END_ADDR  = CMP_W'(i_mem_length);

  typedef enum logic [1:0] {
    ST_GAP  = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [i_addr_width-1:0] pc_q, pc_d;
  logic                    i_req_q, i_req_d;
  logic [i_addr_width-1:0] i_addr_q, i_addr_d;
  logic                    fetch_done_q, fetch_done_d;

  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [7:0]              data_q [fifo_depth];
  logic [7:0]              data_d [fifo_depth];
  logic [i_addr_width-1:0] addr_q [fifo_depth];
  logic [i_addr_width-1:0] addr_d [fifo_depth];

  logic push;
  logic pop;
  logic has_slot;
  logic at_end;

  // Redirect wins over both ack and pop: the ack belongs to the old stream
  // and the popped entry is being flushed anyway.
  always_comb begin
    pop      = (count_q != '0) && inst_ready && !redirect;
    push     = (state_q == ST_REQ) && i_ack && !redirect;
    // A slot freed by this cycle's pop counts, so a full FIFO being drained
    // does not cost an extra idle cycle.
    has_slot = (count_q != FIFO_FULL) || pop;
    // >= rather than == so a jump past the end also lands in DONE.
    at_end   = (CMP_W'(pc_q) >= END_ADDR);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;

    case (state_q)
      ST_GAP: begin
        if (at_end) begin
          state_d = ST_DONE;
        end else if (has_slot) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_ack) begin
          pc_d    = pc_q + PC_ONE;
          state_d = ST_GAP;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_GAP;
      end
    endcase

    if (redirect) begin
      state_d = ST_GAP;
      pc_d    = redirect_addr;
    end

    i_req_d      = (state_d == ST_REQ);
    fetch_done_d = (state_d == ST_DONE);
    // Address is only loaded as the request rises, so it is stable for the
    // whole REQ phase. REQ is only entered from GAP, where pc_d == pc_q.
    i_addr_d     = i_addr_q;
    if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
      i_addr_d = pc_d;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    addr_d   = addr_q;

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = i_rdata;
        addr_d[wr_ptr_q] = pc_q;
        wr_ptr_d         = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GAP;
      pc_q         <= '0;
      i_req_q      <= 1'b0;
      i_addr_q     <= '0;
      fetch_done_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < int'(fifo_depth); i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      i_req_q      <= i_req_d;
      i_addr_q     <= i_addr_d;
      fetch_done_q <= fetch_done_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
    end
  end

  assign i_req      = i_req_q;
  assign i_addr     = i_addr_q;
  assign fetch_done = fetch_done_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = data_q[rd_ptr_q];
  assign inst_addr  = addr_q[rd_ptr_q];

endmodule

// File: tb/tb_bf_ifetch.sv
// Directed bench for bf_ifetch. Instance u_dut_a uses the default program
// length (1024); u_dut_b uses an 8-byte program for the end-of-program cases.
// Each instance has a memory model that acks one cycle after i_req is seen
// and keeps acking while i_req stays high.
module tb_bf_ifetch;

  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_mon = 1'b1;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic          i_req_a, i_ack_a, redirect_a, inst_valid_a, inst_ready_a, fetch_done_a;
  logic [AW-1:0] i_addr_a, redirect_addr_a, inst_addr_a;
  logic [7:0]    i_rdata_a, inst_data_a;

  logic          i_req_b, i_ack_b, redirect_b, inst_valid_b, inst_ready_b, fetch_done_b;
  logic [AW-1:0] i_addr_b, redirect_addr_b, inst_addr_b;
  logic [7:0]    i_rdata_b, inst_data_b;

  bf_ifetch u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req_a), .i_addr(i_addr_a), .i_ack(i_ack_a), .i_rdata(i_rdata_a),
    .redirect(redirect_a), .redirect_addr(redirect_addr_a),
    .inst_valid(inst_valid_a), .inst_ready(inst_ready_a),
    .inst_data(inst_data_a), .inst_addr(inst_addr_a), .fetch_done(fetch_done_a)
  );

  bf_ifetch #(.i_addr_width(16), .i_mem_length(32'd8), .fifo_depth(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req_b), .i_addr(i_addr_b), .i_ack(i_ack_b), .i_rdata(i_rdata_b),
    .redirect(redirect_b), .redirect_addr(redirect_addr_b),
    .inst_valid(inst_valid_b), .inst_ready(inst_ready_b),
    .inst_data(inst_data_b), .inst_addr(inst_addr_b), .fetch_done(fetch_done_b)
  );

  // Program image: fixed bytes at 0..3, elsewhere low address byte ^ 0xA5.
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    case (a)
      16'd0:   mem_byte = 8'h2B;
      16'd1:   mem_byte = 8'h3E;
      16'd2:   mem_byte = 8'h5B;
      16'd3:   mem_byte = 8'h2D;
      default: mem_byte = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_ack_a <= 1'b0; i_rdata_a <= 8'h00;
      i_ack_b <= 1'b0; i_rdata_b <= 8'h00;
    end else begin
      i_ack_a <= i_req_a; i_rdata_a <= mem_byte(i_addr_a);
      i_ack_b <= i_req_b; i_rdata_b <= mem_byte(i_addr_b);
    end
  end

  // Observation: delivered {addr,data}, request rises, accepted acks.
  logic [23:0]   dlv_a[$], dlv_b[$];
  logic [AW-1:0] rise_a[$], rise_b[$];
  int            rise_cyc_a[$];
  int            acks_a = 0, acks_b = 0;
  logic          req_prev_a = 1'b0, req_prev_b = 1'b0;

  always @(negedge clk) begin
    if (clr_mon) begin
      dlv_a.delete(); rise_a.delete(); rise_cyc_a.delete();
      acks_a = 0; req_prev_a = 1'b0;
    end else if (!rst_n) begin
      req_prev_a = 1'b0;
    end else begin
      if (inst_valid_a && inst_ready_a && !redirect_a) dlv_a.push_back({inst_addr_a, inst_data_a});
      if (i_req_a && !req_prev_a) begin
        rise_a.push_back(i_addr_a);
        rise_cyc_a.push_back(cyc_cnt);
      end
      if (i_req_a && i_ack_a && !redirect_a) acks_a++;
      req_prev_a = i_req_a;
    end
  end

  always @(negedge clk) begin
    if (clr_mon) begin
      dlv_b.delete(); rise_b.delete();
      acks_b = 0; req_prev_b = 1'b0;
    end else if (!rst_n) begin
      req_prev_b = 1'b0;
    end else begin
      if (inst_valid_b && inst_ready_b && !redirect_b) dlv_b.push_back({inst_addr_b, inst_data_b});
      if (i_req_b && !req_prev_b) rise_b.push_back(i_addr_b);
      if (i_req_b && i_ack_b && !redirect_b) acks_b++;
      req_prev_b = i_req_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with reset just released.
  task automatic do_reset();
    rst_n   = 1'b0;
    clr_mon = 1'b1;
    cyc(2);
    clr_mon = 1'b0;
    rst_n   = 1'b1;
  endtask

  logic found;

  initial begin
    inst_ready_a = 1'b1; redirect_a = 1'b0; redirect_addr_a = '0;
    inst_ready_b = 1'b1; redirect_b = 1'b0; redirect_addr_b = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_i_req",      i_req_a,      0);
    check("rst_i_addr",     i_addr_a,     0);
    check("rst_inst_valid", inst_valid_a, 0);
    check("rst_inst_data",  inst_data_a,  0);
    check("rst_inst_addr",  inst_addr_a,  0);
    check("rst_fetch_done", fetch_done_a, 0);
    clr_mon = 1'b0;
    rst_n   = 1'b1;

    // T1: sequential fetch with a ready decoder.
    cyc(1);
    check("t1_first_req",  i_req_a,  1);
    check("t1_first_addr", i_addr_a, 0);
    for (int k = 0; k < 40 && dlv_a.size() < 4; k++) cyc(1);
    check("t1_dlv_cnt", 32'(dlv_a.size() >= 4), 1);
    check("t1_dlv0", dlv_a[0], {16'h0000, 8'h2B});
    check("t1_dlv1", dlv_a[1], {16'h0001, 8'h3E});
    check("t1_dlv2", dlv_a[2], {16'h0002, 8'h5B});
    check("t1_dlv3", dlv_a[3], {16'h0003, 8'h2D});
    check("t1_rise0", rise_a[0], 0);
    check("t1_rise1", rise_a[1], 1);
    check("t1_rise2", rise_a[2], 2);
    check("t1_rise3", rise_a[3], 3);
    check("t1_period01", rise_cyc_a[1] - rise_cyc_a[0], 3);
    check("t1_period12", rise_cyc_a[2] - rise_cyc_a[1], 3);
    check("t1_period23", rise_cyc_a[3] - rise_cyc_a[2], 3);

    // T2: back-pressure fills the FIFO, then a single pop allows one fetch.
    inst_ready_a = 1'b0;
    do_reset();
    cyc(30);
    check("t2_acks_full",  acks_a,        4);
    check("t2_rises_full", rise_a.size(), 4);
    check("t2_req_idle",   i_req_a,       0);
    check("t2_valid",      inst_valid_a,  1);
    check("t2_head_data",  inst_data_a,   8'h2B);
    check("t2_head_addr",  inst_addr_a,   0);
    inst_ready_a = 1'b1;
    cyc(1);
    inst_ready_a = 1'b0;
    cyc(10);
    check("t2_acks_after",  acks_a,        5);
    check("t2_rises_after", rise_a.size(), 5);
    check("t2_new_addr",    rise_a[4],     4);
    check("t2_popped",      dlv_a.size(),  1);
    check("t2_head_data2",  inst_data_a,   8'h3E);
    check("t2_head_addr2",  inst_addr_a,   1);
    check("t2_req_idle2",   i_req_a,       0);

    // T3: redirect in the ack cycle of address 2.
    inst_ready_a = 1'b1;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      if (i_req_a && i_addr_a == 16'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_wait_req2", found, 1);
    cyc(1);
    check("t3_req_in_ack_cycle", i_req_a, 1);
    redirect_a = 1'b1; redirect_addr_a = 16'h0010;
    cyc(1);
    redirect_a = 1'b0;
    check("t3_gap_req",   i_req_a,      0);
    check("t3_flushed",   inst_valid_a, 0);
    cyc(1);
    check("t3_req_new",   i_req_a,      1);
    check("t3_addr_new",  i_addr_a,     16'h0010);
    for (int k = 0; k < 20 && dlv_a.size() < 3; k++) cyc(1);
    check("t3_dlv0", dlv_a[0], {16'h0000, 8'h2B});
    check("t3_dlv1", dlv_a[1], {16'h0001, 8'h3E});
    check("t3_dlv2", dlv_a[2], {16'h0010, 8'hB5});

    // T4: redirect while REQ is waiting for its ack.
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      if (i_req_a && i_addr_a == 16'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_wait_req1", found, 1);
    redirect_a = 1'b1; redirect_addr_a = 16'h0020;
    cyc(1);
    redirect_a = 1'b0;
    check("t4_abort_req", i_req_a, 0);
    cyc(1);
    check("t4_req_new",  i_req_a,  1);
    check("t4_addr_new", i_addr_a, 16'h0020);
    for (int k = 0; k < 20 && dlv_a.size() < 2; k++) cyc(1);
    check("t4_dlv0",  dlv_a[0], {16'h0000, 8'h2B});
    check("t4_dlv1",  dlv_a[1], {16'h0020, 8'h85});
    check("t4_acks",  acks_a,   2);

    // T5: 8-byte program runs to the end, then redirects.
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      cyc(1);
      if (fetch_done_b) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_done_seen",  found,   1);
    check("t5_acks_end",   acks_b,  8);
    check("t5_req_end",    i_req_b, 0);
    cyc(10);
    check("t5_rises_end",  rise_b.size(), 8);
    check("t5_dlv_cnt",    dlv_b.size(),  8);
    check("t5_dlv7",       dlv_b[7],      {16'h0007, 8'hA2});
    check("t5_done_hold",  fetch_done_b,  1);
    redirect_b = 1'b1; redirect_addr_b = 16'h0003;
    cyc(1);
    redirect_b = 1'b0;
    check("t5_done_clr",   fetch_done_b, 0);
    check("t5_gap_req",    i_req_b,      0);
    cyc(1);
    check("t5_resume_req",  i_req_b,  1);
    check("t5_resume_addr", i_addr_b, 3);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      cyc(1);
      if (fetch_done_b) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_done_again", found,  1);
    check("t5_acks_total", acks_b, 13);
    cyc(3);
    check("t5_dlv8",  dlv_b[8],  {16'h0003, 8'h2D});
    check("t5_dlv12", dlv_b[12], {16'h0007, 8'hA2});
    // Jump past the end: GAP for one cycle, then DONE without fetching.
    redirect_b = 1'b1; redirect_addr_b = 16'h0040;
    cyc(1);
    redirect_b = 1'b0;
    check("t5_past_done0", fetch_done_b, 0);
    cyc(1);
    check("t5_past_done1", fetch_done_b, 1);
    check("t5_past_req",   i_req_b,      0);
    cyc(5);
    check("t5_past_rises", rise_b.size(), 13);

    // T6: asynchronous reset mid-REQ with two entries queued.
    inst_ready_a = 1'b0;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      if (i_req_a && i_addr_a == 16'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_wait_req2",  found,        1);
    check("t6_pre_valid",  inst_valid_a, 1);
    #2;
    rst_n   = 1'b0;
    clr_mon = 1'b1;
    #1;
    check("t6_async_req",   i_req_a,      0);
    check("t6_async_valid", inst_valid_a, 0);
    check("t6_async_addr",  i_addr_a,     0);
    @(negedge clk);
    #2;
    clr_mon = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    check("t6_restart_req",  i_req_a,  1);
    check("t6_restart_addr", i_addr_a, 0);
    inst_ready_a = 1'b1;
    for (int k = 0; k < 20 && dlv_a.size() < 1; k++) cyc(1);
    check("t6_dlv0", dlv_a[0], {16'h0000, 8'h2B});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
